// File: rtl/ram_display_scanner_if.sv
// Debug read port between the display scanner and the CPU data RAM.
// The RAM returns data_in a fixed number of cycles after disp_addr is presented.
interface ram_display_scanner_if;
  // Handshake: disp_en high qualifies disp_addr, which stays stable for the
  // whole window. There is no ready; the RAM must answer within the fixed
  // latency and data_in is only consumed on the capture cycle.
  logic        disp_en;
  logic [4:0]  disp_addr;
  logic [15:0] data_in;

  modport master (output disp_en, output disp_addr, input data_in);
  modport slave  (input disp_en, input disp_addr, output data_in);
endinterface

// File: rtl/ram_display_scanner.sv
// Steals short read windows on the RAM debug port and shows the captured
// 16-bit word as hex on a 4-digit multiplexed seven-segment display.
module ram_display_scanner #(
  parameter int DWELL   = 50000000,
  parameter int REFRESH = 100000,
  parameter int RD_LAT  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode_seq,
  input  logic                         hold,
  input  logic [4:0]                   sel_addr,
  output logic [4:0]                   cur_addr,
  output logic [3:0]                   an,
  output logic [6:0]                   seg,
  output logic [1:0]                   dbg_state_o,
  output logic [15:0]                  dbg_word_o,
  ram_display_scanner_if.master        ram
);

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DWELL   = 2'd3
  } state_e;

  localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  // The ISSUE cycle is the last idle cycle, so disp_en stays low for exactly DWELL cycles.
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 2);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH - 1);
  localparam logic [1:0]    WAIT_LAST  = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_e         state_q;
  logic           en_q;
  logic [4:0]     addr_q;
  logic [4:0]     cur_q;
  logic [15:0]    word_q;
  logic [DW-1:0]  dwell_q;
  logic [1:0]     wait_q;
  logic [4:0]     sel_prev_q;
  logic [RW-1:0]  ref_q;
  logic [1:0]     digit_q;
  logic [3:0]     an_q;
  logic [6:0]     seg_q;

  logic [4:0]     target_d;
  logic           sel_chg_d;
  logic [3:0]     nib_d;
  logic [6:0]     seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    target_d = sel_addr;
    if (mode_seq) begin
      target_d = hold ? cur_q : cur_q + 5'd1;
    end
    sel_chg_d = (sel_addr != sel_prev_q);
    nib_d     = word_q[{digit_q, 2'b00} +: 4];
    seg_d     = hex7(nib_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ISSUE;
      en_q       <= 1'b0;
      addr_q     <= 5'd0;
      cur_q      <= 5'd0;
      word_q     <= 16'd0;
      dwell_q    <= '0;
      wait_q     <= 2'd0;
      sel_prev_q <= 5'd0;
    end else begin
      sel_prev_q <= sel_addr;
      case (state_q)
        ST_ISSUE: begin
          en_q    <= 1'b1;
          addr_q  <= target_d;
          wait_q  <= 2'd0;
          state_q <= (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        ST_CAPTURE: begin
          word_q  <= ram.data_in;
          cur_q   <= addr_q;
          en_q    <= 1'b0;
          dwell_q <= '0;
          state_q <= ST_DWELL;
        end
        default: begin
          // A manual address change cuts the idle time short for a snappy display.
          if ((!mode_seq && sel_chg_d) || (dwell_q == DWELL_LAST)) begin
            dwell_q <= '0;
            state_q <= ST_ISSUE;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q   <= '0;
      digit_q <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
    end else begin
      if (ref_q == REF_LAST) begin
        ref_q   <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        ref_q <= ref_q + RW'(1);
      end
      an_q  <= ~(4'b0001 << digit_q);
      seg_q <= seg_d;
    end
  end

  assign ram.disp_en   = en_q;
  assign ram.disp_addr = addr_q;
  assign cur_addr      = cur_q;
  assign an            = an_q;
  assign seg           = seg_q;
  assign dbg_state_o   = state_q;
  assign dbg_word_o    = word_q;

endmodule
